sync_decoder_n: RTL and testbench



---
 rtl/dec_pkg.sv | 19 +
 rtl/dwell_counter.sv | 41 ++++
 rtl/sync_decoder_n.sv | 134 +++++++++++++
 tb/tb_sync_decoder_n.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// -----------------------------------------------------------------------------
// dec_pkg
// Shared types and constants for sync_decoder_n and its dwell counter.
//   state_t     : decoder FSM states (IDLE, DIRECT, SCAN)
//   MODE_DIRECT : value of the mode input selecting direct decode
//   MODE_SCAN   : value of the mode input selecting the scanning walk
// -----------------------------------------------------------------------------
package dec_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage : dec_pkg

// File: rtl/dwell_counter.sv
// -----------------------------------------------------------------------------
// dwell_counter
// Free-running dwell counter for the scan walk. While run is high the count
// advances every cycle; when it equals limit, tick is raised and the count
// returns to 0 on that edge. The compare is equality only, so a limit lowered
// below the current count lets the count run on through all-ones and roll
// over before it can match.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   clr    : synchronous clear (wins over run)
//   run    : count enable
//   limit  : compare value, sampled live every cycle
//   tick   : count == limit while running
// -----------------------------------------------------------------------------
module dwell_counter #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               run,
   input  logic [DWELL_W-1:0] limit,
   output logic               tick
);

   logic [DWELL_W-1:0] count_q;

   assign tick = run && (count_q == limit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (run) begin
         count_q <= tick ? '0 : count_q + DWELL_W'(1);
      end
   end

endmodule : dwell_counter

// File: rtl/sync_decoder_n.sv
// -----------------------------------------------------------------------------
// sync_decoder_n
// Registered N-to-2^N one-hot decoder with an optional scanning mode.
//   Direct mode : a qualified select (sel_valid) is decoded to 1 << sel_i one
//                 cycle later; without sel_valid the outputs hold.
//   Scan mode   : the asserted line walks 0..OUT_W-1, each line held dwell+1
//                 cycles; wrap pulses on the return to line 0.
// Build option:
//   SYNC_DECODER_SCAN_EN : when defined, the SCAN state, dwell counter and
//                          wrap logic are built. When undefined, mode and
//                          dwell are ignored (always direct) and wrap is 0.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   en        : block enable; 0 clears out_o/out_valid/wrap, cur_sel holds
//   mode      : 0 = direct, 1 = scan
//   sel_i     : select value for direct mode
//   sel_valid : sel_i qualifier, ignored in scan
//   dwell     : extra cycles each line is held in scan
//   out_o     : registered one-hot (or all-zero) output
//   out_valid : out_o carries a decoded line
//   cur_sel   : index of the currently asserted line
//   wrap      : one-cycle pulse when scan wraps from OUT_W-1 to 0
// -----------------------------------------------------------------------------
module sync_decoder_n
   import dec_pkg::*;
#(
   parameter  int SEL_W   = 3,
   parameter  int DWELL_W = 8,
   localparam int OUT_W   = 2**SEL_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel_i,
   input  logic               sel_valid,
   input  logic [DWELL_W-1:0] dwell,
   output logic [OUT_W-1:0]   out_o,
   output logic               out_valid,
   output logic [SEL_W-1:0]   cur_sel,
   output logic               wrap
);

   localparam logic [OUT_W-1:0] ONE_HOT_0 = OUT_W'(1);

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_d;
   logic [OUT_W-1:0] onehot_d;
   logic             valid_d;
   logic             wrap_d;
   logic             scan_req;

`ifdef SYNC_DECODER_SCAN_EN
   logic tick;
   logic cnt_run;
   logic cnt_clr;

   assign scan_req = en && (mode == MODE_SCAN);
   // Count only while staying in SCAN; every other cycle (entry edge, exit,
   // disable) clears it so each scan entry starts from 0.
   assign cnt_run  = scan_req && (state_q == SCAN);
   assign cnt_clr  = !cnt_run;

   dwell_counter #(
      .DWELL_W (DWELL_W)
   ) u_dwell_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .run   (cnt_run),
      .limit (dwell),
      .tick  (tick)
   );
`else
   logic unused_scan_inputs;

   assign scan_req           = 1'b0;
   assign unused_scan_inputs = ^{mode, dwell};
`endif

   always_comb begin
      state_d  = state_q;
      sel_d    = cur_sel;
      onehot_d = out_o;
      valid_d  = out_valid;
      wrap_d   = 1'b0;

      if (!en) begin
         state_d  = IDLE;
         onehot_d = '0;
         valid_d  = 1'b0;
      end else if (scan_req) begin
`ifdef SYNC_DECODER_SCAN_EN
         if (state_q != SCAN) begin
            state_d  = SCAN;
            sel_d    = '0;
            onehot_d = ONE_HOT_0;
            valid_d  = 1'b1;
         end else if (tick) begin
            sel_d    = cur_sel + SEL_W'(1);
            onehot_d = ONE_HOT_0 << sel_d;
            valid_d  = 1'b1;
            wrap_d   = (cur_sel == '1);
         end
`endif
      end else begin
         // Leaving SCAN without sel_valid freezes the current line.
         state_d = DIRECT;
         if (sel_valid) begin
            sel_d    = sel_i;
            onehot_d = ONE_HOT_0 << sel_i;
            valid_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cur_sel   <= '0;
         out_o     <= '0;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_sel   <= sel_d;
         out_o     <= onehot_d;
         out_valid <= valid_d;
         wrap      <= wrap_d;
      end
   end

endmodule : sync_decoder_n

// File: tb/tb_sync_decoder_n.sv
module tb_sync_decoder_n;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       mode;
   logic [2:0] sel_i;
   logic       sel_valid;
   logic [7:0] dwell;
   logic [7:0] out_o;
   logic       out_valid;
   logic [2:0] cur_sel;
   logic       wrap;

   int total = 0;
   int bad   = 0;

   sync_decoder_n #(
      .SEL_W   (3),
      .DWELL_W (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .sel_i     (sel_i),
      .sel_valid (sel_valid),
      .dwell     (dwell),
      .out_o     (out_o),
      .out_valid (out_valid),
      .cur_sel   (cur_sel),
      .wrap      (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       mode;
      logic       sv;
      logic [2:0] sel;
      logic [7:0] eo;
      logic       ev;
      logic [2:0] es;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chk_all(input string nm, input logic [7:0] eo, input logic ev,
                          input logic [2:0] es, input logic ew);
      chk({nm, ".out_o"},     32'(out_o),     32'(eo));
      chk({nm, ".out_valid"}, 32'(out_valid), 32'(ev));
      chk({nm, ".cur_sel"},   32'(cur_sel),   32'(es));
      chk({nm, ".wrap"},      32'(wrap),      32'(ew));
   endtask

   // Advance one rising edge and settle; inputs are then changed away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic m, input logic sv,
                        input logic [2:0] s, input logic [7:0] d);
      en = e; mode = m; sel_valid = sv; sel_i = s; dwell = d;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
      #12;
      chk_all("reset", 8'h00, 1'b0, 3'd0, 1'b0);
      #5 rst_n = 1'b1;

      // Direct-mode vectors: en, mode, sel_valid, sel_i -> out_o, out_valid, cur_sel
      tbl.push_back('{1'b1, 1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 3'd5});
      for (int unsigned i = 0; i < 4; i++)
         tbl.push_back('{1'b1, 1'b0, 1'b0, 3'd2, 8'h20, 1'b1, 3'd5});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1, 3'd0});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 3'd1, 8'h02, 1'b1, 3'd1});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 3'd2, 8'h04, 1'b1, 3'd2});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 3'd3, 8'h08, 1'b1, 3'd3});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 3'd4, 8'h10, 1'b1, 3'd4});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 3'd5});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 3'd6, 8'h40, 1'b1, 3'd6});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 3'd7});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 3'd7});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0, 3'd7});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 3'd3, 8'h08, 1'b1, 3'd3});

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].en, tbl[i].mode, tbl[i].sv, tbl[i].sel, 8'd0);
         step();
         chk_all($sformatf("vec%0d", i), tbl[i].eo, tbl[i].ev, tbl[i].es, 1'b0);
      end

`ifdef SYNC_DECODER_SCAN_EN
      // Scan with dwell=2: each line 3 cycles, wrap on the 24th edge.
      drive(1'b1, 1'b1, 1'b0, 3'd0, 8'd2);
      step();
      chk_all("scan2.entry", 8'h01, 1'b1, 3'd0, 1'b0);
      for (int k = 1; k <= 28; k++) begin
         int ln;
         ln = (k / 3) % 8;
         step();
         chk_all($sformatf("scan2.k%0d", k), 8'(1 << ln), 1'b1, 3'(ln), (k == 24));
      end

      // Disable mid-scan with sel_valid high: outputs clear, cur_sel holds line 1.
      drive(1'b0, 1'b1, 1'b1, 3'd6, 8'd2);
      step();
      chk_all("scan.en0", 8'h00, 1'b0, 3'd1, 1'b0);

      // Scan with dwell=0: rotate every cycle, wrap every 8 edges.
      drive(1'b1, 1'b1, 1'b0, 3'd0, 8'd0);
      step();
      chk_all("scan0.entry", 8'h01, 1'b1, 3'd0, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         step();
         chk_all($sformatf("scan0.k%0d", k), 8'(1 << (k % 8)), 1'b1, 3'(k % 8), (k % 8 == 0));
      end

      // Mode change to direct with sel_valid on the same edge.
      drive(1'b1, 1'b0, 1'b1, 3'd3, 8'd0);
      step();
      chk_all("scan2dir.load", 8'h08, 1'b1, 3'd3, 1'b0);

      // Scan to direct without sel_valid freezes the current line.
      drive(1'b1, 1'b1, 1'b0, 3'd0, 8'd0);
      step();
      step();
      step();
      chk_all("freeze.pre", 8'h04, 1'b1, 3'd2, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 3'd6, 8'd0);
      step();
      chk_all("freeze.hold", 8'h04, 1'b1, 3'd2, 1'b0);

      // Dwell lowered below the count: counter rolls through all-ones first.
      drive(1'b1, 1'b1, 1'b0, 3'd0, 8'd5);
      step();
      chk_all("shrink.entry", 8'h01, 1'b1, 3'd0, 1'b0);
      step();
      step();
      step();
      dwell = 8'd1;
      for (int k = 0; k < 254; k++) step();
      chk_all("shrink.still0", 8'h01, 1'b1, 3'd0, 1'b0);
      step();
      chk_all("shrink.adv", 8'h02, 1'b1, 3'd1, 1'b0);

      // Asynchronous reset mid-scan, then re-entry from IDLE.
      step();
      rst_n = 1'b0;
      #2;
      chk_all("rst.async", 8'h00, 1'b0, 3'd0, 1'b0);
      #4 rst_n = 1'b1;
      step();
      chk_all("rst.reentry", 8'h01, 1'b1, 3'd0, 1'b0);
      step();
      chk_all("rst.reentry2", 8'h01, 1'b1, 3'd0, 1'b0);
`else
      // Without scan support, mode=1 behaves as direct and wrap stays low.
      drive(1'b1, 1'b1, 1'b1, 3'd6, 8'd0);
      step();
      chk_all("noscan.load", 8'h40, 1'b1, 3'd6, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 3'd1, 8'd0);
      for (int k = 0; k < 10; k++) begin
         step();
         chk_all($sformatf("noscan.hold%0d", k), 8'h40, 1'b1, 3'd6, 1'b0);
      end
      drive(1'b0, 1'b1, 1'b1, 3'd2, 8'd0);
      step();
      chk_all("noscan.en0", 8'h00, 1'b0, 3'd6, 1'b0);
      step();
      rst_n = 1'b0;
      #2;
      chk_all("noscan.rst", 8'h00, 1'b0, 3'd0, 1'b0);
      #4 rst_n = 1'b1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_sync_decoder_n
